code_select_tracker: RTL and testbench

Parametrised code-selection tracker: samples a stream of code values qualified by a valid strobe and reports which codes in the range 1..NUM_CODES have arrived. It generalises the 18-code selector to any code count and adds a second operating mode (last-code one-hot or sticky accumulate). It also adds completion detection with freeze, a received-code population count and a saturating error counter for out-of-range codes. The block sits directly behind the code source and drives the status bus to downstream control logic.

---
 rtl/code_select_tracker.sv | 107 ++++++++++
 tb/tb_code_select_tracker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_select_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : code_select_tracker
// Brief    : Tracks which codes 1..NUM_CODES have arrived (one-hot or sticky),
//            with completion freeze, popcount and saturating error counter.
// Revision : 1.0 - initial release
// =============================================================================
module code_select_tracker #(
  parameter int NUM_CODES = 18,
  parameter int DATA_W    = $clog2(NUM_CODES + 1),
  parameter int ERR_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 data_val_i,
  input  logic                 mode_i,
  input  logic                 clear_i,
  output logic [NUM_CODES-1:0] status_o,
  output logic [DATA_W-1:0]    seen_cnt_o,
  output logic                 done_o,
  output logic [ERR_W-1:0]     err_cnt_o
);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] c_max_code = DATA_W'(NUM_CODES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_CODES-1:0] r_status;
  logic [NUM_CODES-1:0] w_status_nxt;
  logic [NUM_CODES-1:0] w_code_onehot;
  logic [ERR_W-1:0]     r_err_cnt;
  logic [ERR_W-1:0]     w_err_cnt_nxt;
  logic [DATA_W-1:0]    w_seen_cnt;
  logic                 w_in_range;
  logic                 w_legal;
  logic                 w_illegal;

  assign w_in_range = (data_i != '0) && (data_i <= c_max_code);
  assign w_legal    = data_val_i && w_in_range;
  assign w_illegal  = data_val_i && !w_in_range;

  always_comb begin
    w_code_onehot = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      w_code_onehot[k] = (data_i == DATA_W'(k + 1));
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_err_cnt_nxt = r_err_cnt;
    if (clear_i) begin
      // A sample coincident with clear is dropped entirely, including error counting.
      w_state_nxt   = S_COLLECT;
      w_status_nxt  = '0;
      w_err_cnt_nxt = '0;
    end else begin
      if (w_illegal && (r_err_cnt != '1)) begin
        w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
      end
      if ((r_state == S_COLLECT) && w_legal) begin
        if (mode_i) begin
          w_status_nxt = r_status | w_code_onehot;
          if (&w_status_nxt) begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_status_nxt = w_code_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_COLLECT;
      r_status  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_status  <= w_status_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_seen_cnt = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      w_seen_cnt = w_seen_cnt + DATA_W'(r_status[k]);
    end
  end

  assign status_o   = r_status;
  assign seen_cnt_o = w_seen_cnt;
  assign done_o     = (r_state == S_DONE);
  assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_code_select_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_code_select_tracker
// Brief    : Self-checking bench: directed scenarios plus random soak against a
//            set-based reference model for three parameterisations.
// Revision : 1.0 - initial release
// =============================================================================
module tb_code_select_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 18-code instances (default and ERR_W=3)
  logic       rst_n = 1'b0;
  logic [4:0] data  = '0;
  logic       val   = 1'b0;
  logic       mode  = 1'b0;
  logic       clr   = 1'b0;
  // Stimulus for the 5-code instance
  logic [2:0] data5 = '0;
  logic       val5  = 1'b0;
  logic       mode5 = 1'b0;
  logic       clr5  = 1'b0;

  logic [17:0] st18, st_s;
  logic [4:0]  sc18, sc_s;
  logic        dn18, dn_s, dn5;
  logic [7:0]  er18;
  logic [2:0]  er_s, er5, sc5;
  logic [4:0]  st5;

  code_select_tracker #(.NUM_CODES(18), .ERR_W(8)) u_dut18 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data), .data_val_i(val), .mode_i(mode),
    .clear_i(clr), .status_o(st18), .seen_cnt_o(sc18), .done_o(dn18), .err_cnt_o(er18));

  code_select_tracker #(.NUM_CODES(18), .ERR_W(3)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_n), .data_i(data), .data_val_i(val), .mode_i(mode),
    .clear_i(clr), .status_o(st_s), .seen_cnt_o(sc_s), .done_o(dn_s), .err_cnt_o(er_s));

  code_select_tracker #(.NUM_CODES(5), .ERR_W(3)) u_dut5 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data5), .data_val_i(val5), .mode_i(mode5),
    .clear_i(clr5), .status_o(st5), .seen_cnt_o(sc5), .done_o(dn5), .err_cnt_o(er5));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the set of received codes, a done flag and an error count
  bit m_set  [3][1:32];
  bit m_done [3];
  int m_err  [3];
  int n_codes [3] = '{18, 18, 5};
  int err_max [3] = '{255, 7, 7};

  int perm [18];
  int ill  [3] = '{0, 19, 31};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int id, input bit rn, input bit v, input int code,
                            input bit md, input bit cl);
    bit all_in;
    if (!rn || cl) begin
      for (int k = 1; k <= 32; k++) m_set[id][k] = 1'b0;
      m_done[id] = 1'b0;
      m_err[id]  = 0;
      return;
    end
    if (!v) return;
    if (code < 1 || code > n_codes[id]) begin
      if (m_err[id] < err_max[id]) m_err[id]++;
      return;
    end
    if (m_done[id]) return;
    if (!md) begin
      for (int k = 1; k <= 32; k++) m_set[id][k] = 1'b0;
      m_set[id][code] = 1'b1;
    end else begin
      m_set[id][code] = 1'b1;
      all_in = 1'b1;
      for (int k = 1; k <= n_codes[id]; k++) if (!m_set[id][k]) all_in = 1'b0;
      m_done[id] = all_in;
    end
  endtask

  function automatic logic [31:0] exp_status(input int id);
    logic [31:0] s;
    s = '0;
    for (int k = 1; k <= n_codes[id]; k++) if (m_set[id][k]) s[k-1] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_count(input int id);
    int c;
    c = 0;
    for (int k = 1; k <= n_codes[id]; k++) if (m_set[id][k]) c++;
    return 32'(c);
  endfunction

  task automatic check_all();
    chk_eq("a_status", 32'(st18), exp_status(0));
    chk_eq("a_seen",   32'(sc18), exp_count(0));
    chk_eq("a_done",   32'(dn18), 32'(m_done[0]));
    chk_eq("a_err",    32'(er18), 32'(m_err[0]));
    chk_eq("s_status", 32'(st_s), exp_status(1));
    chk_eq("s_seen",   32'(sc_s), exp_count(1));
    chk_eq("s_done",   32'(dn_s), 32'(m_done[1]));
    chk_eq("s_err",    32'(er_s), 32'(m_err[1]));
    chk_eq("c5_status", 32'(st5), exp_status(2));
    chk_eq("c5_seen",   32'(sc5), exp_count(2));
    chk_eq("c5_done",   32'(dn5), 32'(m_done[2]));
    chk_eq("c5_err",    32'(er5), 32'(m_err[2]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, rst_n, val, int'(data), mode, clr);
    model_edge(1, rst_n, val, int'(data), mode, clr);
    model_edge(2, rst_n, val5, int'(data5), mode5, clr5);
    #1;
    check_all();
  endtask

  initial begin
    // Reset held with a pending sample
    rst_n = 1'b0; val = 1'b1; data = 5'd5; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("rst_status", 32'(st18), 32'h0);
      chk_eq("rst_done",   32'(dn18), 32'h0);
    end
    rst_n = 1'b1;
    step();
    chk_eq("post_rst_status", 32'(st18), 32'h10);
    chk_eq("post_rst_seen",   32'(sc18), 32'd1);

    // One-hot mode
    begin
      int oh_code [4] = '{3, 18, 18, 1};
      logic [31:0] oh_exp [4] = '{32'h4, 32'h20000, 32'h20000, 32'h1};
      for (int i = 0; i < 4; i++) begin
        data = 5'(oh_code[i]);
        step();
        chk_eq("onehot_status", 32'(st18), oh_exp[i]);
        chk_eq("onehot_seen",   32'(sc18), 32'd1);
        chk_eq("onehot_done",   32'(dn18), 32'd0);
      end
    end

    // Sticky accumulation from an empty status to completion
    clr = 1'b1; val = 1'b0;
    step();
    clr = 1'b0; mode = 1'b1;
    for (int i = 0; i < 18; i++) perm[i] = i + 1;
    for (int i = 17; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 18; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        val = 1'b0; data = 5'($urandom);
        step();
      end
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        val = 1'b1; data = 5'(perm[$urandom_range(0, i - 1)]);
        step();
        chk_eq("sticky_repeat_done", 32'(dn18), 32'd0);
      end
      val = 1'b1; data = 5'(perm[i]);
      step();
      chk_eq("sticky_done", 32'(dn18), (i == 17) ? 32'd1 : 32'd0);
    end
    chk_eq("done_status", 32'(st18), 32'h3FFFF);
    chk_eq("done_seen",   32'(sc18), 32'd18);
    data = 5'd7;
    step();
    chk_eq("frozen_status", 32'(st18), 32'h3FFFF);
    chk_eq("frozen_done",   32'(dn18), 32'd1);
    data = 5'd0;
    step();
    chk_eq("done_err", 32'(er18), 32'd1);
    chk_eq("done_hold", 32'(dn18), 32'd1);

    // Clear beats a coincident sample
    clr = 1'b1; data = 5'd4;
    step();
    chk_eq("clr_status", 32'(st18), 32'h0);
    chk_eq("clr_done",   32'(dn18), 32'd0);
    chk_eq("clr_err",    32'(er18), 32'd0);
    clr = 1'b0;
    step();
    chk_eq("after_clr_status", 32'(st18), 32'h8);

    // Illegal codes and saturation on the narrow error counter
    for (int i = 0; i < 10; i++) begin
      data = 5'(ill[i % 3]);
      step();
      chk_eq("sat_err",    32'(er_s), 32'((i + 1 > 7) ? 7 : i + 1));
      chk_eq("sat_status", 32'(st_s), 32'h8);
      chk_eq("wide_err",   32'(er18), 32'(i + 1));
    end

    // Random soak, 500 cycles per group
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      val   = ($urandom_range(0, 3) != 0);
      data  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(1, 18));
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      clr   = ($urandom_range(0, 127) == 0);
      val5  = ($urandom_range(0, 3) != 0);
      data5 = 3'($urandom);
      if ($urandom_range(0, 31) == 0) mode5 = ~mode5;
      clr5  = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
